pooling_seq: RTL and testbench

POOLING_SEQ -- requirements
Module: pooling_seq

---
 rtl/pooling_seq.sv | 200 ++++++++++++++++++++
 tb/tb_pooling_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pooling_seq
//  Purpose  : Per-layer sequencer for the pooling datapath. It latches a command,
//             publishes the pool configuration, fires pool_start, and counts
//             input and output tiles until the layer drains.
//  Revision : 1.0  initial release
// ============================================================================
module pooling_seq #(
    parameter int MAX_POOL_SIZE     = 8,
    parameter int MAX_W             = 256,
    parameter int MAX_H             = 256,
    parameter int MAX_AVGPOOL_DENOM = 64,
    parameter int MAX_TILES         = 1024
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [1:0]                           cmd_type,
    input  logic [$clog2(MAX_POOL_SIZE)-1:0]     cmd_size,
    input  logic [$clog2(MAX_POOL_SIZE)-1:0]     cmd_stride,
    input  logic [$clog2(MAX_W)-1:0]             cmd_w,
    input  logic [$clog2(MAX_H)-1:0]             cmd_h,
    input  logic [$clog2(MAX_TILES)-1:0]         cmd_tiles,
    output logic [1:0]                           pool_type,
    output logic [$clog2(MAX_POOL_SIZE)-1:0]     pool_size,
    output logic [$clog2(MAX_POOL_SIZE)-1:0]     pool_stride,
    output logic [$clog2(MAX_W)-1:0]             pool_size_w,
    output logic [$clog2(MAX_H)-1:0]             pool_size_h,
    output logic [$clog2(MAX_AVGPOOL_DENOM)-1:0] pool_avg_pool_denom,
    output logic                                 pool_start,
    input  logic                                 pool_ready,
    input  logic                                 in_valid,
    input  logic                                 in_last_tile_n_elm,
    output logic                                 in_stall,
    input  logic                                 out_valid,
    input  logic                                 out_last_tile_n_elm,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);
    localparam int c_SW = $clog2(MAX_POOL_SIZE);
    localparam int c_WW = $clog2(MAX_W);
    localparam int c_HW = $clog2(MAX_H);
    localparam int c_DW = $clog2(MAX_AVGPOOL_DENOM);
    localparam int c_TW = $clog2(MAX_TILES);
    localparam int c_QW = 2 * c_SW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    logic [1:0]      r_type;
    logic [c_SW-1:0] r_size;
    logic [c_SW-1:0] r_stride;
    logic [c_WW-1:0] r_w;
    logic [c_HW-1:0] r_h;
    logic [c_DW-1:0] r_denom;
    logic [c_TW-1:0] r_tiles;
    logic [c_TW-1:0] r_in_tiles;
    logic [c_TW-1:0] r_out_tiles;
    logic            r_legal;
    logic            r_bypass;
    logic            r_pool_start;
    logic            r_done;
    logic            r_err;

    logic [c_QW-1:0] w_sq;
    logic            w_cmd_bypass;
    logic            w_cmd_legal;
    logic            w_accept;
    logic            w_in_ev;
    logic            w_in_inc;
    logic            w_out_phase;
    logic            w_out_ev;
    logic            w_out_full;
    logic            w_out_inc;
    logic            w_err_set;
    logic [c_TW-1:0] w_in_nxt;
    logic [c_TW-1:0] w_out_nxt;

    assign w_sq         = c_QW'(cmd_size) * c_QW'(cmd_size);
    assign w_cmd_bypass = (cmd_size <= c_SW'(1));
    assign w_cmd_legal  = (cmd_tiles != '0) &&
                          (w_cmd_bypass ||
                           ((cmd_stride != '0) && (cmd_stride <= cmd_size) &&
                            (32'(w_sq) < 32'(MAX_AVGPOOL_DENOM))));

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = cmd_valid & cmd_ready;

    // Bypass layers never back-pressure while running; everything else follows the datapath.
    assign in_stall  = (r_state == S_RUN) ? (~r_bypass & ~pool_ready) : 1'b1;

    assign w_in_ev     = in_valid & in_last_tile_n_elm;
    assign w_in_inc    = (r_state == S_RUN) & w_in_ev & ~in_stall & (r_in_tiles != r_tiles);
    assign w_out_phase = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_out_ev    = (w_out_phase & r_bypass) ? w_in_inc
                                                  : (out_valid & out_last_tile_n_elm);
    assign w_out_full  = (r_out_tiles == r_tiles);
    assign w_out_inc   = w_out_phase & w_out_ev & ~w_out_full;

    assign w_in_nxt  = r_in_tiles + c_TW'(w_in_inc);
    assign w_out_nxt = r_out_tiles + c_TW'(w_out_inc);

    assign w_err_set = (w_in_ev & (r_state != S_RUN)) |
                       (w_out_ev & ((r_state == S_IDLE) | w_out_full)) |
                       ((r_state == S_LOAD) & ~r_legal);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_type       <= '0;
            r_size       <= '0;
            r_stride     <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_denom      <= '0;
            r_tiles      <= '0;
            r_in_tiles   <= '0;
            r_out_tiles  <= '0;
            r_legal      <= 1'b0;
            r_bypass     <= 1'b0;
            r_pool_start <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pool_start <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= w_err_set | (r_err & ~w_accept);
            r_in_tiles   <= w_in_nxt;
            r_out_tiles  <= w_out_nxt;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_tiles  <= cmd_tiles;
                        r_legal  <= w_cmd_legal;
                        r_bypass <= w_cmd_bypass;
                        // Config is captured at accept so it is already stable during LOAD,
                        // one cycle ahead of pool_start; illegal commands leave it untouched.
                        if (w_cmd_legal) begin
                            r_type   <= cmd_type;
                            r_size   <= cmd_size;
                            r_stride <= cmd_stride;
                            r_w      <= cmd_w;
                            r_h      <= cmd_h;
                            r_denom  <= c_DW'(w_sq);
                        end
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_legal) begin
                        r_pool_start <= ~r_bypass;
                        r_state      <= S_START;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_START: r_state <= S_RUN;
                S_RUN: begin
                    if (w_in_nxt == r_tiles) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_out_nxt == r_tiles) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_in_tiles  <= '0;
                    r_out_tiles <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pool_type           = r_type;
    assign pool_size           = r_size;
    assign pool_stride         = r_stride;
    assign pool_size_w         = r_w;
    assign pool_size_h         = r_h;
    assign pool_avg_pool_denom = r_denom;
    assign pool_start          = r_pool_start;
    assign done                = r_done;
    assign err                 = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pooling_seq.sv
`default_nettype none
// Testbench for pooling_seq: directed layer scenarios plus randomized layers,
// each checked cycle by cycle against a rule-based model of the sequencer.
module tb_pooling_seq;
    localparam int         MD        = 64;
    localparam logic [1:0] MAXPOOL2D = 2'd1;
    localparam logic [1:0] AVGPOOL2D = 2'd2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_type;
    logic [2:0] cmd_size, cmd_stride;
    logic [7:0] cmd_w, cmd_h;
    logic [9:0] cmd_tiles;
    logic [1:0] pool_type;
    logic [2:0] pool_size, pool_stride;
    logic [7:0] pool_size_w, pool_size_h;
    logic [5:0] pool_avg_pool_denom;
    logic       pool_start, pool_ready;
    logic       in_valid, in_last_tile_n_elm, in_stall;
    logic       out_valid, out_last_tile_n_elm;
    logic       busy, done, err;

    int checks  = 0;
    int errors  = 0;
    int n_start = 0;
    int n_done  = 0;

    logic [1:0] e_type;
    logic [2:0] e_size, e_stride;
    logic [7:0] e_w, e_h;
    logic [5:0] e_denom;
    logic       e_err;

    pooling_seq #(
        .MAX_POOL_SIZE(8), .MAX_W(256), .MAX_H(256), .MAX_AVGPOOL_DENOM(64), .MAX_TILES(1024)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_size(cmd_size), .cmd_stride(cmd_stride), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_tiles(cmd_tiles),
        .pool_type(pool_type), .pool_size(pool_size), .pool_stride(pool_stride),
        .pool_size_w(pool_size_w), .pool_size_h(pool_size_h),
        .pool_avg_pool_denom(pool_avg_pool_denom), .pool_start(pool_start),
        .pool_ready(pool_ready),
        .in_valid(in_valid), .in_last_tile_n_elm(in_last_tile_n_elm), .in_stall(in_stall),
        .out_valid(out_valid), .out_last_tile_n_elm(out_last_tile_n_elm),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pool_start === 1'b1) n_start <= n_start + 1;
        if (done === 1'b1) n_done <= n_done + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cfg(input string tag);
        chkv({tag, "_type"},   32'(pool_type),           32'(e_type));
        chkv({tag, "_size"},   32'(pool_size),           32'(e_size));
        chkv({tag, "_stride"}, 32'(pool_stride),         32'(e_stride));
        chkv({tag, "_w"},      32'(pool_size_w),         32'(e_w));
        chkv({tag, "_h"},      32'(pool_size_h),         32'(e_h));
        chkv({tag, "_denom"},  32'(pool_avg_pool_denom), 32'(e_denom));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_ready"}, cmd_ready, 1'b1);
        chk1({tag, "_start"}, pool_start, 1'b0);
        chk1({tag, "_stall"}, in_stall, 1'b1);
        chk1({tag, "_busy"},  busy, 1'b0);
        chk1({tag, "_done"},  done, 1'b0);
        chk1({tag, "_err"},   err, 1'b0);
        chk_cfg(tag);
    endtask

    // One full layer. lag: outputs may trail accepted inputs by this many tiles
    // while running (large value = outputs only after the last input).
    task automatic layer(input logic [1:0] t, input int sz, input int st, input int w,
                         input int h, input int tiles, input int stall, input int lag,
                         input bit jit);
        bit legal, byp, fin, dn_next, drain, exp_stall, in_acc;
        int acc_in, acc_out, in_after, s0, d0;
        legal   = (tiles != 0) && (sz <= 1 || (st != 0 && st <= sz && sz * sz < MD));
        byp     = (sz <= 1);
        acc_in  = 0;
        acc_out = 0;
        fin     = 0;
        dn_next = 0;
        s0      = n_start;
        d0      = n_done;

        chk1("idle_ready", cmd_ready, 1'b1);
        chk1("idle_err", err, e_err);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_size  = 3'(sz);
        cmd_stride = 3'(st);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_tiles = 10'(tiles);
        tick();
        cmd_valid = 1'b0;
        if (legal) begin
            e_type = t; e_size = 3'(sz); e_stride = 3'(st);
            e_w = 8'(w); e_h = 8'(h); e_denom = 6'((sz * sz) % MD);
        end
        e_err = 1'b0;
        #1;
        chk_cfg("load");
        chk1("load_busy", busy, 1'b1);
        chk1("load_err", err, 1'b0);
        chk1("load_start", pool_start, 1'b0);
        tick();
        #1;
        if (!legal) begin
            chk1("ill_done", done, 1'b1);
            chk1("ill_err", err, 1'b1);
            chk1("ill_start", pool_start, 1'b0);
            chk_cfg("ill");
            e_err = 1'b1;
        end else begin
            chk1("start_pulse", pool_start, !byp);
            tick();
            for (int c = 0; c < 300 && !fin; c++) begin
                drain      = (acc_in == tiles);
                pool_ready = (c >= stall);
                in_valid   = !drain;
                in_last_tile_n_elm = !drain;
                exp_stall  = drain ? 1'b1 : (byp ? 1'b0 : !pool_ready);
                in_acc     = in_valid && !exp_stall;
                in_after   = acc_in + int'(in_acc);
                if (byp) begin
                    out_valid = 1'b0;
                    acc_out   = in_after;
                end else begin
                    out_valid = (acc_out < tiles) && ((acc_out + lag < in_after) || drain);
                    if (jit && $urandom_range(0, 2) == 0) out_valid = 1'b0;
                    if (out_valid) acc_out++;
                end
                out_last_tile_n_elm = out_valid;
                #1;
                chk1("in_stall", in_stall, exp_stall);
                chk1("run_busy", busy, 1'b1);
                chk1("run_err", err, 1'b0);
                chk1("done", done, dn_next);
                if (dn_next) begin
                    fin = 1;
                end else begin
                    if (drain && acc_out == tiles) dn_next = 1;
                    acc_in = in_after;
                    tick();
                end
            end
            chk1("layer_finished", fin, 1'b1);
        end
        in_valid = 1'b0; in_last_tile_n_elm = 1'b0;
        out_valid = 1'b0; out_last_tile_n_elm = 1'b0;
        tick();
        #1;
        chk1("end_done", done, 1'b0);
        chk1("end_busy", busy, 1'b0);
        chk1("end_ready", cmd_ready, 1'b1);
        chk1("end_err", err, e_err);
        chkv("start_count", 32'(n_start - s0), 32'(legal && !byp));
        chkv("done_count", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        int d0, lg;
        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_type = '0; cmd_size = '0; cmd_stride = '0;
        cmd_w = '0; cmd_h = '0; cmd_tiles = '0; pool_ready = 1'b0;
        in_valid = 1'b0; in_last_tile_n_elm = 1'b0;
        out_valid = 1'b0; out_last_tile_n_elm = 1'b0;
        e_type = '0; e_size = '0; e_stride = '0; e_w = '0; e_h = '0; e_denom = '0; e_err = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // max pool 3x3 stride 2, two tiles, outputs after inputs
        layer(MAXPOOL2D, 3, 2, 8, 8, 2, 0, 99, 1'b0);
        // avg pool 7x7 with datapath back-pressure for 5 run cycles
        layer(AVGPOOL2D, 7, 7, 14, 14, 1, 5, 99, 1'b0);
        // bypass: no pool_start, no stall even with pool_ready low
        layer(MAXPOOL2D, 1, 1, 16, 16, 3, 2, 0, 1'b0);
        // stride 0 is illegal; the following legal command clears err
        layer(MAXPOOL2D, 3, 0, 8, 8, 2, 0, 99, 1'b0);
        layer(AVGPOOL2D, 2, 2, 8, 8, 1, 0, 0, 1'b0);
        // last input tile coincides with first output tile
        layer(MAXPOOL2D, 2, 2, 8, 8, 2, 0, 1, 1'b0);
        out_valid = 1'b1; out_last_tile_n_elm = 1'b1;
        tick();
        out_valid = 1'b0; out_last_tile_n_elm = 1'b0;
        #1;
        chk1("spurious_out_err", err, 1'b1);
        e_err = 1'b1;
        // stride larger than size, and zero tiles
        layer(MAXPOOL2D, 3, 4, 8, 8, 1, 0, 0, 1'b0);
        layer(AVGPOOL2D, 2, 1, 8, 8, 0, 0, 0, 1'b0);

        // reset while draining abandons the layer
        cmd_valid = 1'b1; cmd_type = MAXPOOL2D; cmd_size = 3'd2; cmd_stride = 3'd2;
        cmd_w = 8'd4; cmd_h = 8'd4; cmd_tiles = 10'd1; pool_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_last_tile_n_elm = 1'b1;
        tick();
        in_valid = 1'b0; in_last_tile_n_elm = 1'b0;
        #1;
        chk1("drain_stall", in_stall, 1'b1);
        chk1("drain_busy", busy, 1'b1);
        d0 = n_done;
        resetn = 1'b0;
        #1;
        e_type = '0; e_size = '0; e_stride = '0; e_w = '0; e_h = '0; e_denom = '0; e_err = 1'b0;
        chk_reset_vals("rst_drain");
        repeat (2) tick();
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) tick();
        chkv("rst_no_done", 32'(n_done - d0), 32'd0);
        chk1("rst_ready", cmd_ready, 1'b1);
        layer(MAXPOOL2D, 3, 3, 9, 9, 2, 1, 0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            lg = int'($urandom_range(0, 2));
            layer(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  (lg == 2) ? 99 : lg, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
